// File: rtl/mpt2042_spi_ctrl.sv
// mpt2042_spi_ctrl: arbitrates frame writes and register reads onto the MPT2042 SPI byte engine.
// Define MPT2042_SPI_CTRL_POLL_EN to add autonomous lowest-priority status polling.
module mpt2042_spi_ctrl #(
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 4096
`ifdef MPT2042_SPI_CTRL_POLL_EN
    ,
    parameter int         POLL_PERIOD = 100000,
    parameter logic [7:0] POLL_CMD    = 8'h80
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_req,
    output logic        wr_ack,
    output logic        wr_done,
    output logic        frm_rd_en,
    output logic [5:0]  frm_rd_addr,
    input  logic [7:0]  frm_rd_data,
    input  logic        rd_req,
    input  logic [7:0]  rd_cmd,
    output logic        rd_ack,
    output logic        rd_done,
    output logic [23:0] rd_data,
    output logic        rd_src_poll,
    output logic        err_timeout,
    output logic        ctrl_busy,
    output logic        spi_tx_valid,
    output logic        spi_tx_rw,
    output logic        spi_cmd_type,
    output logic [7:0]  spi_tx_data,
    input  logic        next_byte_vld,
    input  logic        spi_finish_pulse,
    input  logic        spi_rd_vld,
    input  logic [7:0]  spi_rdat
);
    typedef enum logic [2:0] {IDLE, FETCH, START, BUSY, GAP} state_t;

    state_t      state_q, state_d;
    logic        prio_rd_q, prio_rd_d;
    logic        is_rd_q, is_rd_d;
    logic [5:0]  idx_q, idx_d;
    logic        load_q, load_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  nrx_q, nrx_d;
    logic [23:0] sh_q, sh_d;
    logic [23:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;

    logic       idle, busy, pick_rd, pick_wr, pick_poll, grant, feed, rx, finish, timeout;
    logic [7:0] poll_cmd;

    assign idle    = state_q == IDLE;
    assign busy    = state_q == BUSY;
    assign pick_rd = idle & rd_req & (~wr_req | prio_rd_q) & ~sys_rst;
    assign pick_wr = idle & wr_req & ~pick_rd & ~sys_rst;
    assign grant   = pick_rd | pick_wr | pick_poll;
    assign feed    = busy & ~is_rd_q & next_byte_vld & (idx_q != 6'd58);
    assign rx      = busy & is_rd_q & spi_rd_vld & (nrx_q != 2'd3);
    assign finish  = busy & spi_finish_pulse;
    assign timeout = busy & ~spi_finish_pulse & (cnt_q == 16'(TIMEOUT_CYC));

`ifdef MPT2042_SPI_CTRL_POLL_EN
    logic [23:0] pcnt_q, pcnt_d;
    logic        ppend_q, ppend_d;
    logic        psrc_q, psrc_d;
    logic        period;

    assign period    = pcnt_q == 24'(POLL_PERIOD - 1);
    assign pick_poll = idle & ppend_q & ~wr_req & ~rd_req & ~sys_rst;
    assign poll_cmd  = POLL_CMD;
    assign rd_src_poll = done_q & is_rd_q & psrc_q;

    always_comb begin
        pcnt_d  = period ? 24'd0 : pcnt_q + 24'd1;
        ppend_d = (ppend_q & ~pick_poll) | period;
        psrc_d  = grant ? pick_poll : psrc_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pcnt_q  <= '0;
            ppend_q <= 1'b0;
            psrc_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            ppend_q <= ppend_d;
            psrc_q  <= psrc_d;
        end
    end
`else
    assign pick_poll   = 1'b0;
    assign poll_cmd    = 8'h00;
    assign rd_src_poll = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = pick_wr ? FETCH : (pick_rd | pick_poll) ? START : IDLE;
            FETCH:   state_d = START;
            START:   state_d = BUSY;
            BUSY:    state_d = (finish | timeout) ? GAP : BUSY;
            GAP:     state_d = (cnt_q == 16'(GAP_CYC - 1)) ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
        cnt_d     = (state_q == START) ? 16'd1 : (finish | timeout) ? 16'd0 : cnt_q + 16'd1;
        prio_rd_d = pick_rd ? 1'b0 : pick_wr ? 1'b1 : prio_rd_q;
        is_rd_d   = grant ? ~pick_wr : is_rd_q;
        idx_d     = pick_wr ? 6'd0 : feed ? idx_q + 6'd1 : idx_q;
        load_d    = frm_rd_en;
        tx_data_d = load_q ? frm_rd_data : pick_rd ? rd_cmd : pick_poll ? poll_cmd : tx_data_q;
        nrx_d     = grant ? 2'd0 : rx ? nrx_q + 2'd1 : nrx_q;
        sh_d      = grant ? 24'd0 : ~rx ? sh_q :
                    (nrx_q == 2'd0) ? {spi_rdat, sh_q[15:0]} :
                    (nrx_q == 2'd1) ? {sh_q[23:16], spi_rdat, sh_q[7:0]} :
                                      {sh_q[23:8], spi_rdat};
        rd_data_d = (finish & is_rd_q) ? sh_d : rd_data_q;
        done_d    = finish;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b1;
            is_rd_q   <= 1'b0;
            idx_q     <= '0;
            load_q    <= 1'b0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            nrx_q     <= '0;
            sh_q      <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            is_rd_q   <= is_rd_d;
            idx_q     <= idx_d;
            load_q    <= load_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            nrx_q     <= nrx_d;
            sh_q      <= sh_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

    assign wr_ack       = pick_wr;
    assign rd_ack       = pick_rd;
    assign frm_rd_en    = pick_wr | feed;
    assign frm_rd_addr  = feed ? idx_q + 6'd1 : 6'd0;
    assign wr_done      = done_q & ~is_rd_q;
    assign rd_done      = done_q & is_rd_q;
    assign rd_data      = rd_data_q;
    assign err_timeout  = timeout;
    assign ctrl_busy    = ~idle;
    assign spi_tx_valid = state_q == START;
    assign spi_tx_rw    = is_rd_q & ~idle;
    assign spi_cmd_type = is_rd_q & ~idle;
    assign spi_tx_data  = tx_data_q;
endmodule

// File: tb/tb_mpt2042_spi_ctrl.sv
// tb_mpt2042_spi_ctrl: directed scoreboard bench for mpt2042_spi_ctrl with a frame RAM and engine model.
module tb_mpt2042_spi_ctrl;
    localparam int GAP_CYC     = 8;
    localparam int TIMEOUT_CYC = 4096;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wr_req, wr_ack, wr_done, frm_rd_en;
    logic [5:0]  frm_rd_addr;
    logic [7:0]  frm_rd_data;
    logic        rd_req, rd_ack, rd_done, rd_src_poll, err_timeout, ctrl_busy;
    logic [7:0]  rd_cmd;
    logic [23:0] rd_data;
    logic        spi_tx_valid, spi_tx_rw, spi_cmd_type;
    logic [7:0]  spi_tx_data;
    logic        next_byte_vld, spi_finish_pulse, spi_rd_vld;
    logic [7:0]  spi_rdat;

    logic [48:0] outs;
    assign outs = {wr_ack, wr_done, frm_rd_en, frm_rd_addr, rd_ack, rd_done, rd_data, rd_src_poll,
                   err_timeout, ctrl_busy, spi_tx_valid, spi_tx_rw, spi_cmd_type, spi_tx_data};

    mpt2042_spi_ctrl #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_done(wr_done),
        .frm_rd_en(frm_rd_en), .frm_rd_addr(frm_rd_addr), .frm_rd_data(frm_rd_data),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ack(rd_ack), .rd_done(rd_done),
        .rd_data(rd_data), .rd_src_poll(rd_src_poll), .err_timeout(err_timeout),
        .ctrl_busy(ctrl_busy), .spi_tx_valid(spi_tx_valid), .spi_tx_rw(spi_tx_rw),
        .spi_cmd_type(spi_cmd_type), .spi_tx_data(spi_tx_data),
        .next_byte_vld(next_byte_vld), .spi_finish_pulse(spi_finish_pulse),
        .spi_rd_vld(spi_rd_vld), .spi_rdat(spi_rdat)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, wr_done_cnt = 0, rd_done_cnt = 0, err_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [23:0] exp_rd_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the frame RAM (RAM[k]=k+1) answers a read one cycle after frm_rd_en.
    task automatic tick();
        logic       en;
        logic [5:0] a;
        #1;
        en = frm_rd_en;
        a  = frm_rd_addr;
        @(posedge sys_clk);
        #1;
        if (en) frm_rd_data = (a <= 6'd58) ? 8'(a) + 8'd1 : 8'hEE;
        #1;
        cyc++;
        wr_done_cnt += int'(wr_done);
        rd_done_cnt += int'(rd_done);
        err_cnt     += int'(err_timeout);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (ctrl_busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic do_read(input logic [7:0] cmd, input int nb, input logic [23:0] bytes,
                           output int vc, output int fc);
        int n = 0;
        exp_rd_q.push_back(bytes & (24'hFFFFFF << (8 * (3 - nb))));
        rd_req = 1'b1;
        rd_cmd = cmd;
        #1;
        while (!rd_ack && n < 100) begin
            tick();
            n++;
        end
        chk("rd_ack", rd_ack, 1);
        tick();
        rd_req = 1'b0;
        rd_cmd = ~cmd;
        chk("rd_start_valid", spi_tx_valid, 1);
        chk("rd_start_data", spi_tx_data, cmd);
        chk("rd_start_rw_type", {spi_tx_rw, spi_cmd_type}, 2'b11);
        vc = cyc;
        tick();
        next_byte_vld = 1'b1;
        #1;
        chk("rd_nbv_ignored", frm_rd_en, 0);
        for (int i = 0; i < nb; i++) begin
            spi_rd_vld = 1'b1;
            spi_rdat   = bytes[23 - 8 * i -: 8];
            tick();
        end
        spi_rd_vld       = 1'b0;
        next_byte_vld    = 1'b0;
        spi_finish_pulse = 1'b1;
        fc = cyc;
        tick();
        spi_finish_pulse = 1'b0;
        chk("rd_done", rd_done, 1);
        chk("rd_data", rd_data, exp_rd_q.size() != 0 ? exp_rd_q.pop_front() : 24'hx);
        chk("rd_src_poll", rd_src_poll, 0);
        chk("rd_gap_hold", {spi_tx_rw, spi_cmd_type, spi_tx_data}, {2'b11, cmd});
    endtask

    task automatic do_write(input int nfeed, input bit fin, output int ack_cyc, output int vc);
        int n = 0;
        for (int k = 0; k <= nfeed; k++) exp_q.push_back(8'(k + 1));
        wr_req = 1'b1;
        #1;
        while (!wr_ack && n < 100) begin
            tick();
            n++;
        end
        chk("wr_ack", wr_ack, 1);
        chk("wr_first_fetch", {frm_rd_en, frm_rd_addr}, {1'b1, 6'd0});
        ack_cyc = cyc;
        tick();
        wr_req = 1'b0;
        tick();
        chk("wr_start_valid", spi_tx_valid, 1);
        chk("wr_start_rw_type", {spi_tx_rw, spi_cmd_type}, 2'b00);
        chk("byte0", spi_tx_data, exp_q.size() != 0 ? exp_q.pop_front() : 8'hx);
        vc = cyc;
        tick();
        for (int k = 1; k <= nfeed; k++) begin
            next_byte_vld = 1'b1;
            #1;
            chk($sformatf("addr%0d", k), {frm_rd_en, frm_rd_addr}, {1'b1, 6'(k)});
            tick();
            next_byte_vld = 1'b0;
            tick();
            chk($sformatf("byte%0d", k), spi_tx_data, exp_q.size() != 0 ? exp_q.pop_front() : 8'hx);
        end
        if (fin) begin
            if (nfeed == 58) begin
                next_byte_vld = 1'b1;
                #1;
                chk("sat_no_fetch", frm_rd_en, 0);
                tick();
                next_byte_vld = 1'b0;
                tick();
                chk("sat_data_hold", spi_tx_data, 8'h3B);
            end
            spi_finish_pulse = 1'b1;
            tick();
            spi_finish_pulse = 1'b0;
            chk("wr_done", {wr_done, err_timeout}, 2'b10);
            tick();
            chk("wr_done_single", wr_done, 0);
        end
    endtask

    initial begin
        int n, vc1, vc2, fc, ac, wd0, er0;
        sys_rst = 1'b1;
        {wr_req, rd_req, next_byte_vld, spi_finish_pulse, spi_rd_vld} = '0;
        rd_cmd = '0;
        spi_rdat = '0;
        frm_rd_data = '0;
        tick();
        tick();
        chk("reset_outs", outs, 0);
        sys_rst = 1'b0;
        tick();
        chk("idle_outs", outs, 0);

        spi_finish_pulse = 1'b1;
        tick();
        spi_finish_pulse = 1'b0;
        tick();
        chk("finish_in_idle", outs, 0);

        do_read(8'h85, 3, 24'h123456, vc1, fc);
        wait_idle(n);
        chk("rd_gap_len", n, GAP_CYC);
        chk("idle_rw_clear", {spi_tx_rw, spi_cmd_type}, 2'b00);

        do_read(8'h41, 0, 24'hA5A5A5, vc1, fc);
        wait_idle(n);

        wd0 = wr_done_cnt;
        er0 = err_cnt;
        do_write(58, 1'b1, ac, vc1);
        wait_idle(n);
        chk("frame_wr_done_cnt", wr_done_cnt - wd0, 1);
        chk("frame_no_timeout", err_cnt - er0, 0);
        chk("frame_all_bytes", exp_q.size(), 0);
        chk("wr_gap_len", n, GAP_CYC - 1);

        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        rd_cmd = 8'h3C;
        #1;
        chk("arb_both_ack", {rd_ack, wr_ack}, 2'b10);
        do_read(8'h3C, 3, 24'hAABBCC, vc1, fc);
        do_write(0, 1'b1, ac, vc2);
        chk("arb_wr_after_gap", ac - fc, GAP_CYC + 1);
        chk("arb_valid_spacing", (vc2 - vc1) >= GAP_CYC + 1, 1);
        wait_idle(n);

        wd0 = wr_done_cnt;
        do_write(0, 1'b0, ac, vc1);
        n = 0;
        while (!err_timeout && n < 5000) begin
            tick();
            n++;
        end
        chk("timeout_dist", cyc - vc1, TIMEOUT_CYC);
        wait_idle(n);
        chk("timeout_gap_len", n, GAP_CYC + 1);
        chk("timeout_no_done", wr_done_cnt - wd0, 0);
        chk("timeout_single_err", err_cnt - er0, 1);

        do_write(30, 1'b0, ac, vc1);
        sys_rst = 1'b1;
        tick();
        chk("midframe_reset_outs", outs, 0);
        sys_rst = 1'b0;
        tick();
        chk("post_reset_outs", outs, 0);
        wd0 = wr_done_cnt;
        do_write(58, 1'b1, ac, vc1);
        wait_idle(n);
        chk("restart_wr_done_cnt", wr_done_cnt - wd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
